// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared encodings for the writeback path: write-back source
//            select codes and load funct3 values.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Write-back source select
  localparam logic [1:0] C_WB_ALU  = 2'b00;
  localparam logic [1:0] C_WB_LOAD = 2'b01;
  localparam logic [1:0] C_WB_PC4  = 2'b10;
  localparam logic [1:0] C_WB_RSVD = 2'b11;

  // Load funct3 encodings
  localparam logic [2:0] C_F3_LB  = 3'b000;
  localparam logic [2:0] C_F3_LH  = 3'b001;
  localparam logic [2:0] C_F3_LW  = 3'b010;
  localparam logic [2:0] C_F3_LBU = 3'b100;
  localparam logic [2:0] C_F3_LHU = 3'b101;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Purpose  : Combinational load extractor. Picks the byte/half/word addressed
//            by addr_lo out of an aligned memory word, sign- or zero-extends
//            it, and flags illegal funct3 codes and misaligned accesses.
// Ports    : mem_rdata [31:0] in  - raw aligned data-memory word
//            funct3    [2:0]  in  - load type
//            addr_lo   [1:0]  in  - byte offset within the word
//            data      [31:0] out - extracted, extended load value
//            err              out - illegal or misaligned load
// Revision : 1.0 - initial release
// ============================================================================
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data,
  output logic        err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = mem_rdata[7:0];
    case (addr_lo)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
  end

  // Half select uses only addr_lo[1]; addr_lo[0] is checked for alignment.
  assign w_half = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (funct3)
      C_F3_LB:  data = {{24{w_byte[7]}}, w_byte};
      C_F3_LBU: data = {24'd0, w_byte};
      C_F3_LH: begin
        data = {{16{w_half[15]}}, w_half};
        err  = addr_lo[0];
      end
      C_F3_LHU: begin
        data = {16'd0, w_half};
        err  = addr_lo[0];
      end
      C_F3_LW: begin
        data = mem_rdata;
        err  = (addr_lo != 2'd0);
      end
      default: err = 1'b1;
    endcase
  end

endmodule : load_align
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Purpose  : Final pipeline stage. Registers the MEM result, selects the
//            write-back source, aligns loads, drives the register-file write
//            port and the EX forwarding bus, and counts retired instructions.
// Ports    : clk, rst (async, active-low)
//            in_valid/in_ready, stall, flush     - handshake and hazards
//            alu_result, mem_rdata, pc_plus4     - candidate write data
//            wb_sel, funct3, addr_lo, rd_in,
//            reg_write_in                        - per-instruction control
//            Write_Rd_data, Rd_addr, writeControl- register-file write port
//            fwd_valid, fwd_rd, fwd_data         - forwarding bus
//            load_err                            - illegal/misaligned load
//            instret [CNT_W-1:0]                 - retired-instruction count
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      mem_rdata,
  input  logic [31:0]      pc_plus4,
  input  logic [1:0]       wb_sel,
  input  logic [2:0]       funct3,
  input  logic [1:0]       addr_lo,
  input  logic [4:0]       rd_in,
  input  logic             reg_write_in,
  output logic [31:0]      Write_Rd_data,
  output logic [4:0]       Rd_addr,
  output logic             writeControl,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [31:0]      fwd_data,
  output logic             load_err,
  output logic [CNT_W-1:0] instret
);

  logic             r_valid;
  logic [4:0]       r_rd;
  logic             r_reg_write;
  logic [1:0]       r_wb_sel;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;
  logic [31:0]      r_alu;
  logic [31:0]      r_mem;
  logic [31:0]      r_pc4;
  logic [CNT_W-1:0] r_instret;

  logic [31:0]      w_load_data;
  logic             w_align_err;
  logic             w_err;
  logic             w_capture;
  logic [31:0]      w_wb_data;

  assign in_ready  = !stall && !flush;
  assign w_capture = in_valid && in_ready;

  // Stall and flush both insert a bubble; only a real capture refreshes the
  // data fields, so a stalled stage keeps its last contents visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid     <= 1'b0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_wb_sel    <= C_WB_ALU;
      r_funct3    <= '0;
      r_addr_lo   <= '0;
      r_alu       <= '0;
      r_mem       <= '0;
      r_pc4       <= '0;
    end else begin
      r_valid <= w_capture;
      if (w_capture) begin
        r_rd        <= rd_in;
        r_reg_write <= reg_write_in;
        r_wb_sel    <= wb_sel;
        r_funct3    <= funct3;
        r_addr_lo   <= addr_lo;
        r_alu       <= alu_result;
        r_mem       <= mem_rdata;
        r_pc4       <= pc_plus4;
      end
    end
  end

  load_align u_load_align (
    .mem_rdata (r_mem),
    .funct3    (r_funct3),
    .addr_lo   (r_addr_lo),
    .data      (w_load_data),
    .err       (w_align_err)
  );

  // Alignment faults only matter for a live load.
  assign w_err = r_valid && (r_wb_sel == C_WB_LOAD) && w_align_err;

  always_comb begin
    w_wb_data = '0;
    case (r_wb_sel)
      C_WB_ALU:  w_wb_data = r_alu;
      C_WB_LOAD: w_wb_data = w_load_data;
      C_WB_PC4:  w_wb_data = r_pc4;
      default:   w_wb_data = '0;
    endcase
  end

  // Every valid, non-faulting stage cycle retires one instruction, whether
  // or not it writes a register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instret <= '0;
    end else if (r_valid && !w_err) begin
      r_instret <= r_instret + 1'b1;
    end
  end

  assign writeControl  = r_valid && r_reg_write && (r_rd != 5'd0) && !w_err
                         && (r_wb_sel != C_WB_RSVD);
  assign Write_Rd_data = w_wb_data;
  assign Rd_addr       = r_rd;
  assign load_err      = w_err;
  assign fwd_valid     = writeControl;
  assign fwd_rd        = Rd_addr;
  assign fwd_data      = Write_Rd_data;
  assign instret       = r_instret;

endmodule : writeback_stage
`default_nettype wire
